// File: rtl/oled_text_engine_if.sv
// Character stream handshake between application logic and the OLED text engine.
// The app side drives code/valid; the engine answers with ready.
interface oled_text_engine_if;
   logic [6:0] char_code;
   logic       char_valid;
   logic       char_ready;

   modport master (
      output char_code,
      output char_valid,
      input  char_ready
   );

   modport slave (
      input  char_code,
      input  char_valid,
      output char_ready
   );
endinterface

// File: rtl/oled_text_engine.sv
// SSD1306 text controller: power-up/init sequencing, screen clear, glyph streaming and an
// SPI serialiser, all driven from one sequencer with registered panel outputs.
module oled_text_engine #(
   parameter int unsigned CLK_DIV      = 5,
   parameter int unsigned DELAY_CYCLES = 100000,
   parameter int unsigned PAGES        = 4,
   parameter int unsigned COLUMNS      = 128,
   parameter int unsigned GLYPH_W      = 8,
   parameter logic [7:0]  COM_CFG      = 8'h00
) (
   input  logic                   clock,
   input  logic                   reset_n,
   output logic                   oled_spi_clk,
   output logic                   oled_spi_data,
   output logic                   oled_vdd,
   output logic                   oled_vbat,
   output logic                   oled_reset_n,
   output logic                   oled_dc_n,
   oled_text_engine_if.slave      charIf,
   input  logic                   clear_req,
   input  logic                   home_req,
   output logic [6:0]             glyph_addr,
   input  logic [GLYPH_W*8-1:0]   glyph_data,
   output logic [2:0]             cursor_page,
   output logic [6:0]             cursor_col,
   output logic                   init_done
);

   localparam int unsigned DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned DLY_W  = $clog2(DELAY_CYCLES);
   localparam int unsigned BYTES  = PAGES * COLUMNS;
   localparam int unsigned BYTE_W = $clog2(BYTES);
   localparam int unsigned GI_W   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;

   localparam logic [DIV_W-1:0]  DivLast   = DIV_W'(CLK_DIV - 1);
   localparam logic [DLY_W-1:0]  DlyLast   = DLY_W'(DELAY_CYCLES - 1);
   localparam logic [BYTE_W-1:0] ByteLast  = BYTE_W'(BYTES - 1);
   localparam logic [GI_W-1:0]   GlyphLast = GI_W'(GLYPH_W - 1);
   localparam logic [7:0]        ColLast   = 8'(COLUMNS - 1);
   localparam logic [7:0]        PageLast  = 8'(PAGES - 1);

   // Command table segment boundaries
   localparam logic [4:0] StepOff     = 5'd0;
   localparam logic [4:0] StepPumpEnd = 5'd4;
   localparam logic [4:0] StepWin     = 5'd14;
   localparam logic [4:0] StepWinEnd  = 5'd19;

   typedef enum logic [3:0] {
      StPwrVdd,
      StDelay,
      StCmd,
      StRstLo,
      StRstHi,
      StVbat,
      StZero,
      StReady,
      StGlyph,
      StWaitSpi
   } state_e;

   state_e            state;
   state_e            retState;
   logic [4:0]        step;
   logic [DLY_W-1:0]  delayCnt;
   logic [BYTE_W-1:0] byteCnt;
   logic [GI_W-1:0]   glyphIdx;
   logic              doClear;
   logic              clearPend;
   logic              homePend;

   logic              spiActive;
   logic [DIV_W-1:0]  divCnt;
   logic [3:0]        edgeCnt;
   logic [6:0]        shiftReg;

   logic              spiGo;
   logic [7:0]        spiByte;
   logic              spiDc;
   logic [7:0]        glyphByte;
   logic [7:0]        colNext;
   logic              charReady;

   function automatic logic [7:0] cmdByte(input logic [4:0] idx);
      logic [7:0] b;
      case (idx)
         5'd0:    b = 8'hAE;
         5'd1:    b = 8'h8D;
         5'd2:    b = 8'h14;
         5'd3:    b = 8'hD9;
         5'd4:    b = 8'hF1;
         5'd5:    b = 8'h81;
         5'd6:    b = 8'hFF;
         5'd7:    b = 8'hA0;
         5'd8:    b = 8'hC0;
         5'd9:    b = 8'hDA;
         5'd10:   b = COM_CFG;
         5'd11:   b = 8'h20;
         5'd12:   b = 8'h00;
         5'd13:   b = 8'hAF;
         5'd14:   b = 8'h21;
         5'd15:   b = 8'h00;
         5'd16:   b = ColLast;
         5'd17:   b = 8'h22;
         5'd18:   b = 8'h00;
         5'd19:   b = PageLast;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   assign glyphByte = glyph_data[32'(glyphIdx) * 8 +: 8];
   assign colNext   = {1'b0, cursor_col} + 8'(GLYPH_W);

   // A request arriving this very cycle also blocks the character so it is serviced first
   assign charReady = (state == StReady) && !clearPend && !homePend && !clear_req && !home_req;
   assign charIf.char_ready = charReady;

   always_comb begin
      spiGo   = 1'b0;
      spiByte = 8'h00;
      spiDc   = 1'b0;
      if (!spiActive) begin
         unique case (state)
            StCmd: begin
               spiGo   = 1'b1;
               spiByte = cmdByte(step);
            end
            StZero: begin
               spiGo = 1'b1;
               spiDc = 1'b1;
            end
            StGlyph: begin
               spiGo   = 1'b1;
               spiByte = glyphByte;
               spiDc   = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= StPwrVdd;
         retState      <= StPwrVdd;
         step          <= '0;
         delayCnt      <= '0;
         byteCnt       <= '0;
         glyphIdx      <= '0;
         doClear       <= 1'b0;
         clearPend     <= 1'b0;
         homePend      <= 1'b0;
         spiActive     <= 1'b0;
         divCnt        <= '0;
         edgeCnt       <= '0;
         shiftReg      <= '0;
         oled_spi_clk  <= 1'b1;
         oled_spi_data <= 1'b0;
         oled_vdd      <= 1'b1;
         oled_vbat     <= 1'b1;
         oled_reset_n  <= 1'b1;
         oled_dc_n     <= 1'b0;
         glyph_addr    <= '0;
         cursor_page   <= '0;
         cursor_col    <= '0;
         init_done     <= 1'b0;
      end else begin
         // Serialiser: leading high half-period carries the MSB, then 8 low/high pairs;
         // later bits change on the falling edges, away from the panel's rising-edge sample.
         if (spiActive) begin
            if (divCnt == DivLast) begin
               divCnt       <= '0;
               oled_spi_clk <= ~oled_spi_clk;
               edgeCnt      <= edgeCnt + 4'd1;
               if (oled_spi_clk && (edgeCnt != 4'd0)) begin
                  oled_spi_data <= shiftReg[6];
                  shiftReg      <= {shiftReg[5:0], 1'b0};
               end
               if (edgeCnt == 4'd15) begin
                  spiActive <= 1'b0;
               end
            end else begin
               divCnt <= divCnt + DIV_W'(1);
            end
         end
         if (spiGo) begin
            spiActive     <= 1'b1;
            shiftReg      <= spiByte[6:0];
            oled_spi_data <= spiByte[7];
            oled_dc_n     <= spiDc;
            divCnt        <= '0;
            edgeCnt       <= '0;
         end

         if (clear_req) begin
            clearPend <= 1'b1;
            homePend  <= 1'b0;
         end else if (home_req) begin
            homePend <= 1'b1;
         end

         case (state)
            StPwrVdd: begin
               oled_vdd <= 1'b0;
               delayCnt <= DlyLast;
               retState <= StCmd;
               step     <= StepOff;
               state    <= StDelay;
            end
            StDelay: begin
               if (delayCnt == '0) begin
                  state <= retState;
               end else begin
                  delayCnt <= delayCnt - DLY_W'(1);
               end
            end
            StCmd: begin
               if (spiGo) begin
                  step <= step + 5'd1;
                  if (step == StepWin) begin
                     cursor_page <= '0;
                     cursor_col  <= '0;
                  end
                  if (step == StepOff) begin
                     retState <= StRstLo;
                     state    <= StWaitSpi;
                  end else if (step == StepPumpEnd) begin
                     retState <= StVbat;
                     state    <= StWaitSpi;
                  end else if (step == StepWinEnd) begin
                     if (doClear) begin
                        state <= StZero;
                     end else begin
                        retState <= StReady;
                        state    <= StWaitSpi;
                     end
                  end
               end
            end
            StRstLo: begin
               oled_reset_n <= 1'b0;
               delayCnt     <= DlyLast;
               retState     <= StRstHi;
               state        <= StDelay;
            end
            StRstHi: begin
               oled_reset_n <= 1'b1;
               delayCnt     <= DlyLast;
               retState     <= StCmd;
               state        <= StDelay;
            end
            StVbat: begin
               oled_vbat <= 1'b0;
               doClear   <= 1'b1;
               delayCnt  <= DlyLast;
               retState  <= StCmd;
               state     <= StDelay;
            end
            StZero: begin
               if (spiGo) begin
                  if (byteCnt == ByteLast) begin
                     byteCnt  <= '0;
                     retState <= StReady;
                     state    <= StWaitSpi;
                  end else begin
                     byteCnt <= byteCnt + BYTE_W'(1);
                  end
               end
            end
            StWaitSpi: begin
               if (!spiActive) begin
                  state <= retState;
               end
            end
            StReady: begin
               init_done <= 1'b1;
               if (clearPend) begin
                  clearPend <= clear_req;
                  homePend  <= 1'b0;
                  doClear   <= 1'b1;
                  step      <= StepWin;
                  state     <= StCmd;
               end else if (homePend) begin
                  homePend <= home_req & ~clear_req;
                  doClear  <= 1'b0;
                  step     <= StepWin;
                  state    <= StCmd;
               end else if (charIf.char_valid && charReady) begin
                  glyph_addr <= charIf.char_code;
                  glyphIdx   <= GlyphLast;
                  state      <= StGlyph;
               end
            end
            StGlyph: begin
               if (spiGo) begin
                  if (glyphIdx == '0) begin
                     // Horizontal addressing wraps the panel pointer the same way
                     if (colNext >= 8'(COLUMNS)) begin
                        cursor_col <= '0;
                        if (cursor_page == 3'(PAGES - 1)) begin
                           cursor_page <= '0;
                        end else begin
                           cursor_page <= cursor_page + 3'd1;
                        end
                     end else begin
                        cursor_col <= colNext[6:0];
                     end
                     retState <= StReady;
                     state    <= StWaitSpi;
                  end else begin
                     glyphIdx <= glyphIdx - GI_W'(1);
                  end
               end
            end
            default: state <= StPwrVdd;
         endcase
      end
   end

endmodule
